fp_operand_reader: RTL
======================

# fp_operand_reader

Issue-side read port and register-status table for the FP register bank in the Tomasulo datapath. Accepts one instruction per cycle, returns each source operand as a value or as the reservation-station tag that will produce it, and records the destination's new producer tag. Snoops the common data bus (CDB), clears completed producers and drives the register bank's single write port, so it is the read/status counterpart of the 7-entry, 16-bit FP register bank.

## Interface
- DATA_W, 16, operand/register width
- TAG_W, 3, reservation-station tag width; tag 0 = "no producer"
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  instruction presented
- issue_ready  out  1  block can accept this cycle
- src1_addr, src2_addr  in  3  source registers (0 = constant zero)
- dst_addr  in  3  destination register (0 = no destination)
- dst_tag  in  TAG_W  RS tag allocated to this instruction (non-zero)
- R1..R7  in  DATA_W each  current register bank contents
- cdb_valid  in  1  CDB broadcast this cycle
- cdb_tag  in  TAG_W  producer tag on CDB
- cdb_data  in  DATA_W  result on CDB
- writeEnable  out  1  register bank write strobe (combinational)
- dataAddress  out  3  register bank write address (combinational)
- dataIn  out  DATA_W  register bank write data (combinational)
- out_valid  out  1  operand bundle valid
- out_ready  in  1  reservation station accepts bundle
- op1_value, op2_value  out  DATA_W  operand value (meaningful when ready)
- op1_tag, op2_tag  out  TAG_W  pending producer tag (0 when ready)
- op1_ready, op2_ready  out  1  operand value present

## Operation
- Status table Qi[1..7], TAG_W bits each; Qi=0 means register bank value is current.
- Operand resolution per source s at issue: addr 0 → value 0, ready. Qi[s]=0 → value R_s, ready. Qi[s]=cdb_tag with cdb_valid → value cdb_data, ready (same-cycle bypass). Otherwise → tag Qi[s], not ready, value 0.
- Sources resolve against Qi before this instruction's destination update (rd == rs sees the older producer).
- On accepted issue with dst_addr≠0: Qi[dst_addr] ← dst_tag.
- CDB: every Qi entry equal to cdb_tag (at most one) clears to 0; writeEnable=1, dataAddress=that index, dataIn=cdb_data in the same cycle. No match → writeEnable=0, dataAddress=0, dataIn=0.
- Issue and CDB clear hitting the same entry in one cycle: issue wins (Qi ← dst_tag); bank write still occurs.
- Held bundle (out_valid && !out_ready) snoops CDB: a not-ready operand whose tag matches takes cdb_data, ready←1, tag←0.
- cdb_tag 0 never matches anything.

## Timing
- Reset: Qi all 0; out_valid, op*_value, op*_tag, op*_ready all 0. Write-port outputs follow CDB combinationally (0 when cdb_valid=0).
- Issue latency 1: bundle registered at the accepting edge, out_valid high the next cycle.
- issue_ready = !out_valid || out_ready (single output stage, full throughput).
- Accept on issue_valid && issue_ready; bundle leaves on out_valid && out_ready; both on the same edge replace the bundle.
- No accept and bundle consumed → out_valid←0.
- Bank updates at the CDB edge; from the next cycle R_n holds the value and Qi=0, so no stale window.
- reset_n asserted mid-operation clears table and bundle immediately; in-flight tags are forgotten.

## Structure
- Shared package: DATA_W, TAG_W, NO_TAG=0, register-address width (3), register count (7).
- One natural sub-module: fp_operand_resolve (combinational, per source: addr, Qi entry, bank value, CDB → value/tag/ready), instanced twice.
- Status table, output stage and write-port decode in the top.

## Test plan
- Reset with R1..R7=1,1,1,2,0,1,0; issue src1=4, src2=0, dst=5, tag=2 → next cycle op1=2 ready, op2=0 ready; Qi[5]=2.
- Then issue src1=5, dst=5, tag=3 → op1_tag=2, not ready; Qi[5]=3.
- CDB tag=3, data=0x00AA → writeEnable=1, dataAddress=5, dataIn=0x00AA; Qi[5]=0; next read of R5 ready with bank value.
- Same-cycle CDB tag=2 data=0x0011 while issuing src1 with Qi=2 → op1=0x0011 ready (bypass).
- Hold out_ready=0 with op1 pending tag 4; CDB tag 4 data 0x1234 → held op1 becomes 0x1234 ready; issue_ready stays 0 until out_ready.
- Issue dst=1 tag=6 in the same cycle CDB clears Qi[1] → Qi[1]=6, writeEnable=1 to address 1; assert reset_n low mid-stream → out_valid=0 and all Qi=0 immediately.

Source files
------------

// File: rtl/fp_operand_reader_pkg.sv
// -----------------------------------------------------------------------------
// fp_operand_reader_pkg
//   Shared widths, types and a small helper for the FP register read port and
//   register-status table (Tomasulo issue side).
//
//   DATA_W   : operand / register width
//   TAG_W    : reservation-station tag width (tag 0 means "no producer")
//   REG_AW   : register address width (address 0 is the constant-zero source)
//   NUM_REGS : number of architectural FP registers (R1..R7)
// -----------------------------------------------------------------------------
package fp_operand_reader_pkg;

    localparam int DATA_W   = 16;
    localparam int TAG_W    = 3;
    localparam int REG_AW   = 3;
    localparam int NUM_REGS = 7;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [REG_AW-1:0] raddr_t;

    localparam tag_t NO_TAG = '0;

    // One resolved source operand: either a value (ready=1, tag=0) or the
    // tag of the reservation station that will produce it (ready=0, value=0).
    typedef struct packed {
        data_t value;
        tag_t  tag;
        logic  ready;
    } operand_t;

    // True when a valid CDB broadcast carries the producer tag t. Tag 0 is
    // never broadcast as a real producer, so it can never match.
    function automatic logic cdb_hits(input logic cdb_valid,
                                      input tag_t cdb_tag,
                                      input tag_t t);
        return cdb_valid && (cdb_tag != NO_TAG) && (t == cdb_tag);
    endfunction

endpackage

// File: rtl/fp_operand_resolve.sv
// -----------------------------------------------------------------------------
// fp_operand_resolve
//   Combinational resolution of one source operand at issue time.
//
//   addr       in  : source register address (0 = constant zero)
//   qi         in  : status-table entry for addr (NO_TAG when bank is current)
//   bank_value in  : register bank contents for addr
//   cdb_valid  in  : CDB broadcast this cycle
//   cdb_tag    in  : producer tag on the CDB
//   cdb_data   in  : result on the CDB
//   operand    out : resolved value / tag / ready
// -----------------------------------------------------------------------------
module fp_operand_resolve
    import fp_operand_reader_pkg::*;
(
    input  raddr_t   addr,
    input  tag_t     qi,
    input  data_t    bank_value,
    input  logic     cdb_valid,
    input  tag_t     cdb_tag,
    input  data_t    cdb_data,
    output operand_t operand
);

    always_comb begin
        operand = '0;
        if (addr == '0) begin
            // Register 0 reads as constant zero and is always available.
            operand.ready = 1'b1;
        end else if (qi == NO_TAG) begin
            operand.value = bank_value;
            operand.ready = 1'b1;
        end else if (cdb_hits(cdb_valid, cdb_tag, qi)) begin
            // Producer completes this very cycle: forward the CDB result so
            // the instruction does not wait on a tag that is about to vanish.
            operand.value = cdb_data;
            operand.ready = 1'b1;
        end else begin
            operand.tag = qi;
        end
    end

endmodule

// File: rtl/fp_operand_reader.sv
// -----------------------------------------------------------------------------
// fp_operand_reader
//   Issue-side read port and register-status table (Qi) for the 7-entry FP
//   register bank. Resolves two source operands per issued instruction,
//   records the destination's new producer tag, snoops the CDB to clear
//   completed producers and drives the bank's single write port.
//
//   clock, reset_n                 : clock, async active-low reset
//   issue_valid / issue_ready      : instruction handshake
//   src1_addr, src2_addr, dst_addr : register addresses (0 = zero / none)
//   dst_tag                        : RS tag allocated to the instruction
//   R1..R7                         : current register bank contents
//   cdb_valid, cdb_tag, cdb_data   : common data bus
//   writeEnable, dataAddress,
//   dataIn                         : bank write port (combinational from CDB)
//   out_valid / out_ready          : operand bundle handshake
//   op1_*, op2_*                   : operand bundle (value, tag, ready)
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// valid, once high, stays high with stable payload (apart from CDB snooping
// of a held bundle) until the transfer; ready may depend combinationally on
// the consumer's ready (issue_ready = !out_valid || out_ready) but never on
// the producer's valid.
// -----------------------------------------------------------------------------
module fp_operand_reader
    import fp_operand_reader_pkg::*;
(
    input  logic         clock,
    input  logic         reset_n,

    input  logic         issue_valid,
    output logic         issue_ready,
    input  raddr_t       src1_addr,
    input  raddr_t       src2_addr,
    input  raddr_t       dst_addr,
    input  tag_t         dst_tag,

    input  data_t        R1,
    input  data_t        R2,
    input  data_t        R3,
    input  data_t        R4,
    input  data_t        R5,
    input  data_t        R6,
    input  data_t        R7,

    input  logic         cdb_valid,
    input  tag_t         cdb_tag,
    input  data_t        cdb_data,

    output logic         writeEnable,
    output raddr_t       dataAddress,
    output data_t        dataIn,

    output logic         out_valid,
    input  logic         out_ready,
    output data_t        op1_value,
    output data_t        op2_value,
    output tag_t         op1_tag,
    output tag_t         op2_tag,
    output logic         op1_ready,
    output logic         op2_ready
);

    // Status table; index 0 is not stored because register 0 never has a
    // producer.
    tag_t                qi_q   [1:NUM_REGS];
    tag_t                qi_view[0:NUM_REGS];
    data_t               bank   [0:NUM_REGS];
    logic [NUM_REGS:1]   cdb_match;

    operand_t            op1_res, op2_res;
    operand_t            op1_q,   op2_q;
    logic                out_valid_q;
    logic                accept;

    // ---------------------------------------------------------------- views
    always_comb begin
        bank[0]    = '0;
        bank[1]    = R1;
        bank[2]    = R2;
        bank[3]    = R3;
        bank[4]    = R4;
        bank[5]    = R5;
        bank[6]    = R6;
        bank[7]    = R7;
        qi_view[0] = NO_TAG;
        for (int i = 1; i <= NUM_REGS; i++) begin
            qi_view[i] = qi_q[i];
        end
    end

    // ------------------------------------------------------- source resolve
    fp_operand_resolve u_resolve_src1 (
        .addr       (src1_addr),
        .qi         (qi_view[src1_addr]),
        .bank_value (bank[src1_addr]),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .operand    (op1_res)
    );

    fp_operand_resolve u_resolve_src2 (
        .addr       (src2_addr),
        .qi         (qi_view[src2_addr]),
        .bank_value (bank[src2_addr]),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .operand    (op2_res)
    );

    // ------------------------------------------------- write-port decode
    // Tags are unique among live producers, so at most one entry matches;
    // the bank write mirrors the CDB result into that register this cycle.
    always_comb begin
        cdb_match   = '0;
        writeEnable = 1'b0;
        dataAddress = '0;
        dataIn      = '0;
        for (int i = 1; i <= NUM_REGS; i++) begin
            if (cdb_hits(cdb_valid, cdb_tag, qi_q[i])) begin
                cdb_match[i] = 1'b1;
                writeEnable  = 1'b1;
                dataAddress  = raddr_t'(i);
                dataIn       = cdb_data;
            end
        end
    end

    // ------------------------------------------------------- handshake
    assign issue_ready = !out_valid_q || out_ready;
    assign accept      = issue_valid && issue_ready;

    // ------------------------------------------------------- status table
    // A new producer written by issue takes priority over a CDB clear of the
    // same entry: the older producer's result still reaches the bank, but the
    // register's future value now belongs to the newly issued instruction.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i <= NUM_REGS; i++) begin
                qi_q[i] <= NO_TAG;
            end
        end else begin
            for (int i = 1; i <= NUM_REGS; i++) begin
                if (accept && (dst_addr == raddr_t'(i))) begin
                    qi_q[i] <= dst_tag;
                end else if (cdb_match[i]) begin
                    qi_q[i] <= NO_TAG;
                end
            end
        end
    end

    // ------------------------------------------------------- output stage
    function automatic operand_t snoop(input operand_t o,
                                       input logic     v,
                                       input tag_t     t,
                                       input data_t    d);
        operand_t r;
        r = o;
        if (!o.ready && cdb_hits(v, t, o.tag)) begin
            r.value = d;
            r.tag   = NO_TAG;
            r.ready = 1'b1;
        end
        return r;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            op1_q       <= op1_res;
            op2_q       <= op2_res;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end else if (out_valid_q) begin
            // Held bundle keeps watching the CDB so it never leaves with a
            // tag whose result has already been broadcast.
            op1_q <= snoop(op1_q, cdb_valid, cdb_tag, cdb_data);
            op2_q <= snoop(op2_q, cdb_valid, cdb_tag, cdb_data);
        end
    end

    assign out_valid = out_valid_q;
    assign op1_value = op1_q.value;
    assign op1_tag   = op1_q.tag;
    assign op1_ready = op1_q.ready;
    assign op2_value = op2_q.value;
    assign op2_tag   = op2_q.tag;
    assign op2_ready = op2_q.ready;

endmodule
